// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, read-scanner state encoding and pixel tag record.
package fb_pkg;

   localparam int FB_WIDTH  = 640;
   localparam int FB_HEIGHT = 480;
   localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
   localparam int FB_X_W    = 10;
   localparam int FB_Y_W    = 9;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } fb_rd_state_t;

   // Coordinates and frame markers that travel alongside each pixel.
   typedef struct packed {
      logic [FB_X_W-1:0] x;
      logic [FB_Y_W-1:0] y;
      logic              sof;
      logic              eof;
   } fb_tag_t;

endpackage

// File: rtl/fb_scan_reader_if.sv
// Frame RAM read port plus the tagged pixel stream toward the display/replay path.
interface fb_scan_reader_if
   import fb_pkg::*;
#(
   parameter int PIX_W = 1
);
   logic              rd_en;
   logic [FB_X_W-1:0] rd_x;
   logic [FB_Y_W-1:0] rd_y;
   logic [PIX_W-1:0]  rd_data;

   logic              out_valid;
   logic              out_ready;
   logic [PIX_W-1:0]  out_pixel;
   logic [FB_X_W-1:0] out_x;
   logic [FB_Y_W-1:0] out_y;
   logic              out_sof;
   logic              out_eof;

   modport master (
      output rd_en, rd_x, rd_y,
      input  rd_data,
      output out_valid, out_pixel, out_x, out_y, out_sof, out_eof,
      input  out_ready
   );

   modport slave (
      input  rd_en, rd_x, rd_y,
      output rd_data,
      input  out_valid, out_pixel, out_x, out_y, out_sof, out_eof,
      output out_ready
   );
endinterface

// File: rtl/fb_skid_fifo.sv
// Two-entry register FIFO holding returned pixels with their tags until the stream accepts them.
module fb_skid_fifo
   import fb_pkg::*;
#(
   parameter int PIX_W = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [PIX_W-1:0] push_pixel,
   input  fb_tag_t          push_tag,
   input  logic             pop,
   output logic [PIX_W-1:0] head_pixel,
   output fb_tag_t          head_tag,
   output logic [1:0]       occ
);

   logic [PIX_W-1:0] pix_mem [2];
   fb_tag_t          tag_mem [2];
   logic             wr_ptr;
   logic             rd_ptr;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

   // NOTE: storage is deliberately not reset; occ qualifies the head, so stale entries are never observed.
   always_ff @(posedge clk) begin
      if (push) begin
         pix_mem[wr_ptr] <= push_pixel;
         tag_mem[wr_ptr] <= push_tag;
      end
   end

   assign head_pixel = pix_mem[rd_ptr];
   assign head_tag   = tag_mem[rd_ptr];

endmodule

// File: rtl/fb_scan_reader.sv
// Column-major frame buffer read scanner: credit-limited RAM reads feeding a valid/ready pixel stream.
module fb_scan_reader
   import fb_pkg::*;
#(
   parameter int WIDTH  = FB_WIDTH,
   parameter int HEIGHT = FB_HEIGHT,
   parameter int PIX_W  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   fb_scan_reader_if.master bus,
   output logic             busy,
   output logic             frame_done
);

   localparam logic [FB_X_W-1:0] X_LAST = FB_X_W'(WIDTH - 1);
   localparam logic [FB_Y_W-1:0] Y_LAST = FB_Y_W'(HEIGHT - 1);

   fb_rd_state_t      state;
   logic [FB_X_W-1:0] x_q;
   logic [FB_Y_W-1:0] y_q;
   logic              inflight_q;
   fb_tag_t           tag_q;
   fb_tag_t           head_tag;
   logic [1:0]        occ;
   logic [2:0]        credit;
   logic              pop;
   logic              issue;
   logic              last_addr;
   logic              drain_done;

   // Entries the FIFO must still absorb after this cycle's pop; a new read needs one free slot.
   assign pop        = bus.out_valid & bus.out_ready;
   assign credit     = {1'b0, occ} - {2'b0, pop} + {2'b0, inflight_q};
   assign issue      = (state == ISSUE) && (credit < 3'd2);
   assign last_addr  = (x_q == X_LAST) && (y_q == Y_LAST);
   assign drain_done = (state == DRAIN) && !inflight_q && (credit == 3'd0);

   assign bus.rd_en = issue;
   assign bus.rd_x  = x_q;
   assign bus.rd_y  = y_q;

   fb_skid_fifo #(
      .PIX_W (PIX_W)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (inflight_q),
      .push_pixel (bus.rd_data),
      .push_tag   (tag_q),
      .pop        (pop),
      .head_pixel (bus.out_pixel),
      .head_tag   (head_tag),
      .occ        (occ)
   );

   assign bus.out_valid = (occ != 2'd0);
   assign bus.out_x     = head_tag.x;
   assign bus.out_y     = head_tag.y;
   assign bus.out_sof   = bus.out_valid & head_tag.sof;
   assign bus.out_eof   = bus.out_valid & head_tag.eof;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         inflight_q <= 1'b0;
         tag_q      <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         inflight_q <= issue;
         frame_done <= 1'b0;
         if (issue) begin
            tag_q <= '{x: x_q, y: y_q, sof: (x_q == '0) && (y_q == '0), eof: last_addr};
         end

         case (state)
            IDLE: begin
               // A start coinciding with the completion pulse is held off by one cycle.
               if (start && !frame_done) begin
                  state <= ISSUE;
                  x_q   <= '0;
                  y_q   <= '0;
                  busy  <= 1'b1;
               end
            end
            ISSUE: begin
               if (issue) begin
                  if (last_addr) begin
                     state <= DRAIN;
                  end else if (y_q == Y_LAST) begin
                     y_q <= '0;
                     x_q <= x_q + 1'b1;
                  end else begin
                     y_q <= y_q + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (drain_done) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_scan_reader.sv
// Self-checking bench for fb_scan_reader on a reduced frame against a column-major reference order.
module tb_fb_scan_reader;
   import fb_pkg::*;

   localparam int W     = 40;
   localparam int H     = 30;
   localparam int N     = W * H;
   localparam int PIX_W = 4;

   typedef struct {
      int x;
      int y;
   } coord_t;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic busy;
   logic frame_done;

   fb_scan_reader_if #(.PIX_W(PIX_W)) bus ();

   fb_scan_reader #(
      .WIDTH  (W),
      .HEIGHT (H),
      .PIX_W  (PIX_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .bus        (bus),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Synchronous-read frame RAM whose contents are x ^ y.
   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= PIX_W'(int'(bus.rd_x) ^ int'(bus.rd_y));
   end

   int n_asserts = 0;
   int n_fail    = 0;

   int n_out, done_cnt, done_cyc, first_valid_cyc, first_rd_cyc, last_rd_cyc, eof_cyc, stall_hits;

   function automatic logic [PIX_W-1:0] model_pixel(input int x, input int y);
      return PIX_W'(x ^ y);
   endfunction

   // Drives one frame from start, checking read order, credit limit, output order and stall stability.
   task automatic run_frame(input int ready_pct, input bit wrap_stall, input int pulse_a,
                            input int pulse_b, input int abort_at, input bit exit_on_done,
                            input int max_cycles);
      coord_t            exp_q[$];
      coord_t            iss_q[$];
      coord_t            e;
      int                pending;
      int                tail;
      bit                acc;
      bit                held;
      bit                exp_sof;
      bit                exp_eof;
      logic [PIX_W-1:0]  held_pix;
      logic [FB_X_W-1:0] held_x;
      logic [FB_Y_W-1:0] held_y;
      logic              held_sof;
      logic              held_eof;
      for (int x = 0; x < W; x++) begin
         for (int y = 0; y < H; y++) begin
            e.x = x;
            e.y = y;
            exp_q.push_back(e);
            iss_q.push_back(e);
         end
      end
      n_out = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
      first_rd_cyc = -1; last_rd_cyc = -1; eof_cyc = -1; stall_hits = 0;
      pending = 0; tail = 0; held = 1'b0;
      held_pix = '0; held_x = '0; held_y = '0; held_sof = 1'b0; held_eof = 1'b0;

      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= max_cycles; c++) begin
         if (c == abort_at) return;
         start = (c == pulse_a) || (c == pulse_b);
         if (wrap_stall && bus.out_valid && bus.out_x == '0 &&
             bus.out_y == FB_Y_W'(H - 1) && stall_hits < 3) begin
            bus.out_ready = 1'b0;
            stall_hits++;
         end else begin
            bus.out_ready = ($urandom_range(99) < ready_pct);
         end
         #1;
         acc = bus.out_valid && bus.out_ready;
         if (frame_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end

         n_asserts++;
         if (busy !== (done_cnt == 0))
            begin n_fail++; $display("FAIL busy: cycle %0d got %0b expected %0b", c, busy, done_cnt == 0); end

         if (bus.rd_en) begin
            n_asserts++;
            if (iss_q.size() == 0) begin
               n_fail++; $display("FAIL read_extra: cycle %0d read (%0d,%0d) after last address", c, bus.rd_x, bus.rd_y);
            end else begin
               e = iss_q.pop_front();
               if (int'(bus.rd_x) != e.x || int'(bus.rd_y) != e.y) begin
                  n_fail++;
                  $display("FAIL read_addr: cycle %0d got (%0d,%0d) expected (%0d,%0d)", c, bus.rd_x, bus.rd_y, e.x, e.y);
               end
            end
            n_asserts++;
            if (pending - int'(acc) > 1) begin
               n_fail++; $display("FAIL read_credit: cycle %0d read with %0d outstanding after pop, limit 1", c, pending - int'(acc));
            end
            pending++;
            if (first_rd_cyc < 0) first_rd_cyc = c;
            last_rd_cyc = c;
         end

         if (held) begin
            n_asserts++;
            if (bus.out_valid !== 1'b1 || bus.out_pixel !== held_pix || bus.out_x !== held_x ||
                bus.out_y !== held_y || bus.out_sof !== held_sof || bus.out_eof !== held_eof) begin
               n_fail++;
               $display("FAIL stall_hold: cycle %0d got v=%0b (%0d,%0d) p=%0h expected v=1 (%0d,%0d) p=%0h",
                        c, bus.out_valid, bus.out_x, bus.out_y, bus.out_pixel, held_x, held_y, held_pix);
            end
         end

         if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = c;
         if (acc) begin
            n_asserts++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL out_extra: cycle %0d pixel (%0d,%0d) beyond frame", c, bus.out_x, bus.out_y);
            end else begin
               e = exp_q.pop_front();
               exp_sof = (e.x == 0) && (e.y == 0);
               exp_eof = (e.x == W - 1) && (e.y == H - 1);
               if (int'(bus.out_x) != e.x || int'(bus.out_y) != e.y || bus.out_pixel !== model_pixel(e.x, e.y) ||
                   bus.out_sof !== exp_sof || bus.out_eof !== exp_eof) begin
                  n_fail++;
                  $display("FAIL out_pixel: cycle %0d got (%0d,%0d) p=%0h sof=%0b eof=%0b expected (%0d,%0d) p=%0h sof=%0b eof=%0b",
                           c, bus.out_x, bus.out_y, bus.out_pixel, bus.out_sof, bus.out_eof,
                           e.x, e.y, model_pixel(e.x, e.y), exp_sof, exp_eof);
               end
               if (exp_eof) eof_cyc = c;
            end
            n_out++;
            pending--;
         end

         held     = bus.out_valid && !bus.out_ready;
         held_pix = bus.out_pixel;
         held_x   = bus.out_x;
         held_y   = bus.out_y;
         held_sof = bus.out_sof;
         held_eof = bus.out_eof;

         if (done_cnt > 0) begin
            if (exit_on_done) return;
            tail++;
            if (tail > 30) return;
         end
         @(posedge clk); #1;
      end
      n_asserts++;
      n_fail++;
      $display("FAIL frame_timeout: no completion within %0d cycles, got %0d pixels expected %0d", max_cycles, n_out, N);
   endtask

   task automatic check_idle_outputs(input string tag);
      n_asserts++;
      if (bus.rd_en !== 1'b0 || bus.rd_x !== '0 || bus.rd_y !== '0 || bus.out_valid !== 1'b0 ||
          bus.out_sof !== 1'b0 || bus.out_eof !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: got rd_en=%0b rd=(%0d,%0d) valid=%0b sof=%0b eof=%0b busy=%0b done=%0b expected all zero",
                  tag, bus.rd_en, bus.rd_x, bus.rd_y, bus.out_valid, bus.out_sof, bus.out_eof, busy, frame_done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_idle_outputs("reset_values");
      @(posedge clk); #1;
      check_idle_outputs("idle_hold");
   endtask

   task automatic test_free_running();
      run_frame(100, 1'b0, -1, -1, -1, 1'b0, N + 100);
      n_asserts++;
      if (n_out != N) begin n_fail++; $display("FAIL free_count: got %0d expected %0d", n_out, N); end
      n_asserts++;
      if (done_cnt != 1) begin n_fail++; $display("FAIL free_done_count: got %0d expected 1", done_cnt); end
      n_asserts++;
      if (first_rd_cyc != 1) begin n_fail++; $display("FAIL free_first_read: got cycle %0d expected 1", first_rd_cyc); end
      n_asserts++;
      if (first_valid_cyc != 3) begin n_fail++; $display("FAIL free_first_valid: got cycle %0d expected 3", first_valid_cyc); end
      n_asserts++;
      if (last_rd_cyc != N) begin n_fail++; $display("FAIL free_last_read: got cycle %0d expected %0d", last_rd_cyc, N); end
      n_asserts++;
      if (eof_cyc != N + 2) begin n_fail++; $display("FAIL free_eof: got cycle %0d expected %0d", eof_cyc, N + 2); end
      n_asserts++;
      if (done_cyc != N + 3) begin n_fail++; $display("FAIL free_done: got cycle %0d expected %0d", done_cyc, N + 3); end
   endtask

   task automatic test_back_pressure();
      run_frame(50, 1'b0, -1, -1, -1, 1'b0, 8 * N);
      n_asserts++;
      if (n_out != N) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", n_out, N); end
      n_asserts++;
      if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_wrap_boundary();
      run_frame(100, 1'b1, -1, -1, -1, 1'b0, N + 100);
      n_asserts++;
      if (stall_hits != 3) begin n_fail++; $display("FAIL wrap_stalled: got %0d stall cycles expected 3", stall_hits); end
      n_asserts++;
      if (n_out != N) begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", n_out, N); end
   endtask

   task automatic test_start_while_busy();
      run_frame(100, 1'b0, 5, 1000, -1, 1'b0, N + 100);
      n_asserts++;
      if (done_cnt != 1) begin n_fail++; $display("FAIL busy_start_done_count: got %0d expected 1", done_cnt); end
      n_asserts++;
      if (done_cyc != N + 3) begin n_fail++; $display("FAIL busy_start_done: got cycle %0d expected %0d", done_cyc, N + 3); end
      n_asserts++;
      if (n_out != N) begin n_fail++; $display("FAIL busy_start_count: got %0d expected %0d", n_out, N); end
   endtask

   task automatic test_reset_mid_frame();
      run_frame(100, 1'b0, -1, -1, 500, 1'b0, N + 100);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check_idle_outputs("midreset_values");
      @(posedge clk); #1;
      check_idle_outputs("midreset_no_stale");
      run_frame(100, 1'b0, -1, -1, -1, 1'b0, N + 100);
      n_asserts++;
      if (first_valid_cyc != 3) begin n_fail++; $display("FAIL midreset_first_valid: got cycle %0d expected 3", first_valid_cyc); end
      n_asserts++;
      if (n_out != N) begin n_fail++; $display("FAIL midreset_count: got %0d expected %0d", n_out, N); end
   endtask

   task automatic test_back_to_back();
      run_frame(100, 1'b0, -1, -1, -1, 1'b1, N + 100);
      start = 1'b1;
      @(posedge clk); #1;
      n_asserts++;
      if (busy !== 1'b0 || bus.rd_en !== 1'b0) begin
         n_fail++; $display("FAIL b2b_start_on_done: got busy=%0b rd_en=%0b expected 0 0", busy, bus.rd_en);
      end
      run_frame(100, 1'b0, -1, -1, -1, 1'b0, N + 100);
      n_asserts++;
      if (first_valid_cyc != 3) begin n_fail++; $display("FAIL b2b_first_valid: got cycle %0d expected 3", first_valid_cyc); end
      n_asserts++;
      if (n_out != N) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", n_out, N); end
      n_asserts++;
      if (done_cyc != N + 3) begin n_fail++; $display("FAIL b2b_done: got cycle %0d expected %0d", done_cyc, N + 3); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_free_running();
      test_back_pressure();
      test_wrap_boundary();
      test_start_while_busy();
      test_reset_mid_frame();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
